encoder_dense_mac: RTL and testbench

Sequential multiply-accumulate engine for one neuron of the encoder dense layer; it is the encoder-side counterpart of the decoder datapath.
- Accepts a stream of (signed 16-bit activation, unsigned 9-bit weight) pairs over a valid/ready handshake.
- Accumulates N_IN products, then applies round-half-up requantization, ReLU and saturation.
- Emits one signed code word over a valid/ready output handshake.
- Sits between the encoder input buffer and the latent-code FIFO feeding the decoder.

---
 rtl/encoder_dense_mac.sv | 95 +++++++++
 tb/tb_encoder_dense_mac.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/encoder_dense_mac.sv
// Sequential MAC for one encoder dense-layer neuron: accumulates N_IN
// activation*weight products, then emits a rounded, ReLU'd, saturated code word.
module encoder_dense_mac #(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned ACT_W = 16,
    parameter int unsigned WGT_W = 9,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic signed [ACT_W-1:0] in_act,
    input  logic        [WGT_W-1:0] in_wgt,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    ap_idle
);

    localparam int unsigned PROD_W = ACT_W + WGT_W + 1;
    localparam int unsigned CNT_W  = $clog2(N_IN + 1);
    localparam int unsigned RQ_W   = ACC_W + 1;
    localparam logic [CNT_W-1:0]       LAST = CNT_W'(N_IN - 1);
    localparam logic signed [RQ_W-1:0] RND  = RQ_W'(2 ** (SHIFT - 1));
    localparam logic signed [RQ_W-1:0] MAXV = RQ_W'(2 ** (OUT_W - 1) - 1);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic        [CNT_W-1:0]   count;

    logic signed [PROD_W-1:0]  prod_c;
    logic signed [ACC_W-1:0]   sum_c;
    logic signed [RQ_W-1:0]    r_c;
    logic signed [OUT_W-1:0]   q_c;

    // Weight is zero-extended so the signed multiply treats it as unsigned.
    always_comb begin
        prod_c = $signed(in_act) * $signed({1'b0, in_wgt});
        sum_c  = acc + ACC_W'(prod_c);
        r_c    = ($signed({sum_c[ACC_W-1], sum_c}) + RND) >>> SHIFT;
        if (r_c < 0)
            q_c = '0;
        else if (r_c > MAXV)
            q_c = OUT_W'(MAXV);
        else
            q_c = r_c[OUT_W-1:0];
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= ST_ACC;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b0;
            ap_idle   <= 1'b1;
        end else begin
            case (state)
                ST_ACC: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        acc     <= sum_c;
                        ap_idle <= 1'b0;
                        if (count == LAST) begin
                            count     <= '0;
                            out_data  <= q_c;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= ST_OUT;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        in_ready  <= 1'b1;
                        ap_idle   <= 1'b1;
                        state     <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_dense_mac.sv
// Directed bench for encoder_dense_mac with hand-computed expected codes.
module tb_encoder_dense_mac;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic signed [15:0] in_act;
    logic        [8:0]  in_wgt;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               ap_idle;

    int n_assert = 0;
    int n_fail   = 0;

    encoder_dense_mac dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_act    (in_act),
        .in_wgt    (in_wgt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ap_idle   (ap_idle)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // One vector: first beat uses act0, remaining beats use act_rest.
    task automatic send_vec(input int act0, input int act_rest, input int wgt);
        for (int i = 0; i < 8; i++) begin
            in_act   = (i == 0) ? 16'(act0) : 16'(act_rest);
            in_wgt   = 9'(wgt);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Checks the code and that out_valid lasts exactly one cycle with out_ready high.
    task automatic check_result(input string tag, input int exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'($unsigned(out_data)), 32'(exp));
        check({tag, "_idle_out"}, 32'(ap_idle), 32'd0);
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_back"}, 32'(ap_idle), 32'd1);
    endtask

    initial begin
        ap_rst    = 1'b1;
        in_act    = '0;
        in_wgt    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'($unsigned(out_data)), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_idle", 32'(ap_idle), 32'd1);
        tick();
        ap_rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);

        send_vec(256, 256, 1);
        check_result("basic", 8);

        send_vec(-1000, -1000, 100);
        check_result("relu", 0);

        send_vec(32767, 32767, 511);
        check_result("sat", 32767);

        send_vec(128, 0, 1);
        check_result("round_up", 1);
        send_vec(127, 0, 1);
        check_result("round_down", 0);
        send_vec(-129, 0, 1);
        check_result("round_neg", 0);

        // Backpressure: offered beats must not be consumed while output is pending.
        out_ready = 1'b0;
        send_vec(256, 256, 1);
        in_act   = 16'sd9999;
        in_wgt   = 9'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'($unsigned(out_data)), 32'd8);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        send_vec(512, 512, 1);
        check_result("after_bp", 16);

        // Reset mid-vector discards the partial sum.
        for (int i = 0; i < 3; i++) begin
            in_act   = 16'sd1000;
            in_wgt   = 9'd1;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("partial_idle", 32'(ap_idle), 32'd0);
        #2;
        ap_rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_idle", 32'(ap_idle), 32'd1);
        check("midrst_ready", 32'(in_ready), 32'd0);
        #1;
        ap_rst = 1'b0;
        tick();
        check("midrst_ready_back", 32'(in_ready), 32'd1);
        send_vec(256, 256, 1);
        check_result("after_rst", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
